// File: rtl/aes_apb_pkg.sv
// Shared types and constants for the APB front-end of the AES core.
// Optional build macro AES_APB_TIMEOUT_EN is consumed by aes_apb_slave.
package aes_apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = 4;

    // Core register map (byte offsets)
    localparam logic [APB_ADDR_W-1:0] REG_R0_OFF      = 32'h0000_0000;
    localparam logic [APB_ADDR_W-1:0] REG_R1_OFF      = 32'h0000_0004;
    localparam logic [APB_ADDR_W-1:0] REG_R2_OFF      = 32'h0000_0008;
    localparam logic [APB_ADDR_W-1:0] REG_R3_OFF      = 32'h0000_000C;
    localparam logic [APB_ADDR_W-1:0] REG_KEY_OFF     = 32'h0000_0010;
    localparam logic [APB_ADDR_W-1:0] REG_COMMAND_OFF = 32'h0000_004C;
    localparam logic [APB_ADDR_W-1:0] AES_MAX_ADDR    = 32'h0000_004C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_ISSUE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_DONE
    } apb_state_t;

    // Captured write presented to the core register file
    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] data;
        logic [APB_STRB_W-1:0] strb;
    } wr_req_t;

endpackage

// File: rtl/aes_apb_slave_if.sv
// APB3 bus bundle between an APB master and the AES register front-end.
interface aes_apb_slave_if;
    import aes_apb_pkg::*;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_ADDR_W-1:0] PADDR;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_STRB_W-1:0] PSTRB;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/aes_apb_timeout.sv
// Saturating busy-wait counter; expired_c flags the last allowed wait cycle.
module aes_apb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts wait cycles while run is high, clears as soon as it drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/aes_apb_slave.sv
// APB3 slave translating transfers into AES core register-file strobes.
// Build macro AES_APB_TIMEOUT_EN adds a busy-wait timeout on stalled writes.
module aes_apb_slave
    import aes_apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] MAX_ADDR       = AES_MAX_ADDR,
    parameter int unsigned           RD_LAT         = 1,
    parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARSTn,
    aes_apb_slave_if.slave        apb,
    input  logic                  enable_amba,
    output logic                  wr_amba,
    output logic [APB_STRB_W-1:0] strb,
    output logic [APB_DATA_W-1:0] data_in,
    output logic [APB_ADDR_W-1:0] addr_wc,
    output logic [APB_ADDR_W-1:0] addr_rc,
    input  logic [APB_DATA_W-1:0] data_out
);

    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    apb_state_t            state_q, state_d;
    wr_req_t               wr_q, wr_d;
    logic [APB_ADDR_W-1:0] addr_rc_q, addr_rc_d;
    logic [APB_DATA_W-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  wr_amba_q, wr_amba_d;
    logic [1:0]            rd_cnt_q, rd_cnt_d;
    logic                  access_c;
    logic                  addr_err_c;
    logic                  timeout_c;

`ifdef AES_APB_TIMEOUT_EN
    aes_apb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (ACLK),
        .rst_n     (ARSTn),
        .run       (state_q == ST_WR_WAIT),
        .expired_c (timeout_c)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    assign access_c   = apb.PSEL && apb.PENABLE;
    assign addr_err_c = (apb.PADDR[1:0] != 2'b00) || (apb.PADDR > MAX_ADDR);

    // Next-state and next-output decode
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_rc_d = addr_rc_q;
        prdata_d  = prdata_q;
        rd_cnt_d  = rd_cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        wr_amba_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (access_c) begin
                    if (addr_err_c) begin
                        state_d   = ST_DONE;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                    end else if (apb.PWRITE) begin
                        wr_d = '{addr: apb.PADDR, data: apb.PWDATA, strb: apb.PSTRB};
                        if (enable_amba) begin
                            state_d   = ST_WR_ISSUE;
                            wr_amba_d = 1'b1;
                            pready_d  = 1'b1;
                        end else begin
                            state_d = ST_WR_WAIT;
                        end
                    end else begin
                        addr_rc_d = apb.PADDR;
                        rd_cnt_d  = '0;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end

            ST_WR_WAIT: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (enable_amba) begin
                    state_d   = ST_WR_ISSUE;
                    wr_amba_d = 1'b1;
                    pready_d  = 1'b1;
                end else if (timeout_c) begin
                    state_d   = ST_DONE;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end
            end

            ST_WR_ISSUE: state_d = ST_IDLE;

            // Reads ignore enable_amba so status can be polled mid-operation
            ST_RD_ADDR, ST_RD_WAIT: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (rd_cnt_q == RD_LAST) begin
                    prdata_d = data_out;
                    pready_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                    state_d  = ST_RD_WAIT;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q   <= ST_IDLE;
            wr_q      <= '0;
            addr_rc_q <= '0;
            prdata_q  <= '0;
            rd_cnt_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            wr_amba_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_rc_q <= addr_rc_d;
            prdata_q  <= prdata_d;
            rd_cnt_q  <= rd_cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            wr_amba_q <= wr_amba_d;
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign wr_amba     = wr_amba_q;
    assign strb        = wr_q.strb;
    assign data_in     = wr_q.data;
    assign addr_wc     = wr_q.addr;
    assign addr_rc     = addr_rc_q;

endmodule

// File: tb/tb_aes_apb_slave.sv
// Directed plus randomized APB traffic against a word-array model of the AES register file.
module tb_aes_apb_slave;
    import aes_apb_pkg::*;

    localparam logic [31:0] MAX_A   = 32'h0000_004C;
    localparam int          RD_LAT  = 1;
    localparam int          TMO     = 16;

    logic        ACLK;
    logic        ARSTn;
    logic        enable_amba;
    logic        wr_amba;
    logic [3:0]  strb;
    logic [31:0] data_in, addr_wc, addr_rc, data_out;

    aes_apb_slave_if apb ();

    aes_apb_slave #(
        .MAX_ADDR       (MAX_A),
        .RD_LAT         (RD_LAT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK        (ACLK),
        .ARSTn       (ARSTn),
        .apb         (apb),
        .enable_amba (enable_amba),
        .wr_amba     (wr_amba),
        .strb        (strb),
        .data_in     (data_in),
        .addr_wc     (addr_wc),
        .addr_rc     (addr_rc),
        .data_out    (data_out)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int          checks   = 0;
    int          failures = 0;
    int          wr_cnt   = 0;
    logic [31:0] last_wa, last_wd;
    logic [3:0]  last_ws;
    logic [31:0] core_mem [0:31];
    logic [31:0] ref_mem  [0:19];

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Stand-in for the core register file: commits on the write strobe
    always @(negedge ACLK) begin
        if (wr_amba === 1'b1) begin
            wr_cnt++;
            last_wa = addr_wc;
            last_wd = data_in;
            last_ws = strb;
            core_mem[addr_wc[6:2]] = merge(core_mem[addr_wc[6:2]], data_in, strb);
        end
    end

    assign data_out = core_mem[addr_rc[6:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; busy>0 holds enable_amba low for that many cycles, busy<0 keeps it low
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int busy, input int limit,
                            output int lat, output logic [31:0] rdata, output logic err,
                            output logic [31:0] rc_t1, output logic wr_at_rdy, output logic one_cycle);
        @(posedge ACLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
        apb.PADDR = addr; apb.PWDATA = wdata; apb.PSTRB = be;
        enable_amba = (busy == 0);
        @(posedge ACLK); #1;
        apb.PENABLE = 1'b1;
        lat = 0; rdata = '0; err = 1'b0; rc_t1 = '0; wr_at_rdy = 1'b0; one_cycle = 1'b0;
        while (lat < limit) begin
            @(posedge ACLK); #1;
            lat++;
            if (lat == 1) rc_t1 = addr_rc;
            if (apb.PREADY === 1'b1) break;
            if (busy > 0 && lat == busy) enable_amba = 1'b1;
        end
        if (apb.PREADY === 1'b1) begin
            rdata = apb.PRDATA; err = apb.PSLVERR; wr_at_rdy = wr_amba;
            @(posedge ACLK); #1;
        end else begin
            lat = 0;
        end
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        one_cycle = (apb.PREADY === 1'b0);
    endtask

    int          lat, w0, busy;
    logic [31:0] rd, rc, addr, wd, expv;
    logic        err, wrr, one, is_wr, exp_err;
    logic [3:0]  be;

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0; apb.PSTRB = '0;
        enable_amba = 1'b1;
        ARSTn = 1'b0;
        #1;
        chk("reset_pready",  32'(apb.PREADY),  32'd0);
        chk("reset_pslverr", 32'(apb.PSLVERR), 32'd0);
        chk("reset_prdata",  apb.PRDATA,       32'd0);
        chk("reset_wr_amba", 32'(wr_amba),     32'd0);
        chk("reset_addr_wc", addr_wc,          32'd0);
        #22 ARSTn = 1'b1;

        // Preload every register with random data through the bus
        for (int i = 0; i < 20; i++) begin
            wd = $urandom;
            apb_xfer(1'b1, 32'(i * 4), wd, 4'hF, 0, 50, lat, rd, err, rc, wrr, one);
            chk("preload_lat", 32'(lat), 32'd1);
            chk("preload_data", last_wd, wd);
            ref_mem[i] = wd;
        end

        // Write with idle core
        w0 = wr_cnt;
        apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 50, lat, rd, err, rc, wrr, one);
        ref_mem[4] = 32'hDEADBEEF;
        chk("wr_idle_lat", 32'(lat), 32'd1);
        chk("wr_idle_err", 32'(err), 32'd0);
        chk("wr_idle_strobe_with_ready", 32'(wrr), 32'd1);
        chk("wr_idle_count", 32'(wr_cnt - w0), 32'd1);
        chk("wr_idle_addr", last_wa, 32'h10);
        chk("wr_idle_data", last_wd, 32'hDEADBEEF);
        chk("wr_idle_strb", 32'(last_ws), 32'hF);
        chk("wr_idle_ready_one_cycle", 32'(one), 32'd1);

        // Write with busy core for 20 cycles
        w0 = wr_cnt;
        apb_xfer(1'b1, 32'h14, 32'h0BADF00D, 4'h5, 20, 100, lat, rd, err, rc, wrr, one);
        ref_mem[5] = merge(ref_mem[5], 32'h0BADF00D, 4'h5);
        chk("wr_busy_lat", 32'(lat), 32'd21);
        chk("wr_busy_strobe_with_ready", 32'(wrr), 32'd1);
        chk("wr_busy_count", 32'(wr_cnt - w0), 32'd1);
        chk("wr_busy_strb", 32'(last_ws), 32'h5);

        // Read while the core is busy
        apb_xfer(1'b1, 32'h04, 32'h12345678, 4'hF, 0, 50, lat, rd, err, rc, wrr, one);
        ref_mem[1] = 32'h12345678;
        apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, -1, 50, lat, rd, err, rc, wrr, one);
        chk("rd_busy_addr_rc_t1", rc, 32'h04);
        chk("rd_busy_lat", 32'(lat), 32'(1 + RD_LAT));
        chk("rd_busy_data", rd, 32'h12345678);
        chk("rd_busy_err", 32'(err), 32'd0);
        chk("rd_ready_one_cycle", 32'(one), 32'd1);

        // Error accesses: misaligned and beyond the map
        w0 = wr_cnt;
        apb_xfer(1'b0, 32'h02, 32'h0, 4'h0, 0, 50, lat, rd, err, rc, wrr, one);
        chk("err_misalign_lat", 32'(lat), 32'd1);
        chk("err_misalign_slverr", 32'(err), 32'd1);
        chk("err_misalign_prdata", rd, 32'd0);
        apb_xfer(1'b1, 32'h50, 32'hFFFF_FFFF, 4'hF, 0, 50, lat, rd, err, rc, wrr, one);
        chk("err_range_lat", 32'(lat), 32'd1);
        chk("err_range_slverr", 32'(err), 32'd1);
        chk("err_range_prdata", rd, 32'd0);
        chk("err_no_core_write", 32'(wr_cnt - w0), 32'd0);

        // Zero-strobe write changes nothing
        apb_xfer(1'b1, 32'h08, 32'hA5A5A5A5, 4'h0, 0, 50, lat, rd, err, rc, wrr, one);
        chk("wr_nostrb_lat", 32'(lat), 32'd1);
        chk("wr_nostrb_strb", 32'(last_ws), 32'h0);
        apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 0, 50, lat, rd, err, rc, wrr, one);
        chk("wr_nostrb_readback", rd, ref_mem[2]);

        // Asynchronous reset during a stalled write
        @(posedge ACLK); #1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 32'h20; apb.PWDATA = 32'hCAFEF00D; apb.PSTRB = 4'hF;
        enable_amba = 1'b0;
        @(posedge ACLK); #1;
        apb.PENABLE = 1'b1;
        repeat (4) begin @(posedge ACLK); #1; end
        chk("rst_mid_stalled", 32'(apb.PREADY), 32'd0);
        w0 = wr_cnt;
        #2 ARSTn = 1'b0;
        #1;
        chk("rst_mid_pready",  32'(apb.PREADY),  32'd0);
        chk("rst_mid_pslverr", 32'(apb.PSLVERR), 32'd0);
        chk("rst_mid_prdata",  apb.PRDATA,       32'd0);
        chk("rst_mid_wr_amba", 32'(wr_amba),     32'd0);
        chk("rst_mid_addr_wc", addr_wc,          32'd0);
        chk("rst_mid_addr_rc", addr_rc,          32'd0);
        chk("rst_mid_data_in", data_in,          32'd0);
        chk("rst_mid_strb",    32'(strb),        32'd0);
        #2;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; enable_amba = 1'b1;
        @(posedge ACLK); #3 ARSTn = 1'b1;
        repeat (3) begin @(posedge ACLK); #1; end
        chk("rst_no_late_write", 32'(wr_cnt - w0), 32'd0);
        apb_xfer(1'b1, 32'h20, 32'h600DF00D, 4'hF, 0, 50, lat, rd, err, rc, wrr, one);
        ref_mem[8] = 32'h600DF00D;
        chk("post_rst_wr_lat", 32'(lat), 32'd1);
        chk("post_rst_wr_data", last_wd, 32'h600DF00D);

        // Write stalled indefinitely
        w0 = wr_cnt;
        apb_xfer(1'b1, 32'h24, 32'h11111111, 4'hF, -1, 40, lat, rd, err, rc, wrr, one);
`ifdef AES_APB_TIMEOUT_EN
        chk("timeout_lat", 32'(lat), 32'(TMO + 1));
        chk("timeout_slverr", 32'(err), 32'd1);
`else
        chk("no_timeout_never_ready", 32'(lat), 32'd0);
`endif
        chk("stall_no_core_write", 32'(wr_cnt - w0), 32'd0);

        // Randomized traffic checked against the register-array model
        for (int n = 0; n < 60; n++) begin
            is_wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       addr = 32'($urandom_range(0, 19) * 4 + $urandom_range(1, 3));
                1:       addr = 32'h50 + 32'($urandom_range(0, 200) * 4);
                default: addr = 32'($urandom_range(0, 19) * 4);
            endcase
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            busy = is_wr ? int'($urandom_range(0, 3)) : (($urandom_range(0, 1) == 1) ? -1 : 0);
            exp_err = (addr[1:0] != 2'b00) || (addr > MAX_A);
            w0 = wr_cnt;
            apb_xfer(is_wr, addr, wd, be, busy, 50, lat, rd, err, rc, wrr, one);
            chk("rnd_err", 32'(err), 32'(exp_err));
            if (exp_err) begin
                chk("rnd_err_lat", 32'(lat), 32'd1);
                chk("rnd_err_prdata", rd, 32'd0);
                chk("rnd_err_nowrite", 32'(wr_cnt - w0), 32'd0);
            end else if (is_wr) begin
                ref_mem[addr[6:2]] = merge(ref_mem[addr[6:2]], wd, be);
                chk("rnd_wr_lat", 32'(lat), 32'(busy + 1));
                chk("rnd_wr_count", 32'(wr_cnt - w0), 32'd1);
            end else begin
                expv = ref_mem[addr[6:2]];
                chk("rnd_rd_lat", 32'(lat), 32'(1 + RD_LAT));
                chk("rnd_rd_data", rd, expv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
